alu_rr_scheduler: RTL

- Round-robin scheduler that shares one 4-bit sequential ALU between NUM_REQ requesters.
- Sits between the requester ports and the ALU. Accepts one operation at a time over a valid/ready handshake, issues it to the ALU with a single-cycle enable, captures the registered 5-bit result and returns it to the granted requester over a valid/ready response handshake.
- Only one transaction is in flight at a time; there is no pipelining.

---
 rtl/alu_rr_scheduler_if.sv | 30 +++
 rtl/alu_rr_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: requester-side handshake bundle for alu_rr_scheduler.
//   req_valid/req_ready   per-requester operation handshake (one-hot ready)
//   req_a/req_b/req_op    packed operands and opcode, requester i at [4i+3:4i] / [2i+1:2i]
//   rsp_valid/rsp_ready   per-requester response handshake (one-hot valid)
//   rsp_data              shared 5-bit signed result
//   rsp_drop              one-cycle pulse when a response is dropped on timeout
// Modports: master = requester side, slave = scheduler side.
interface alu_rr_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [4:0]           rsp_data;
    logic                 rsp_drop;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_drop
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_drop
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one registered 4-bit ALU between NUM_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> CAPT -> RESP -> IDLE, round-robin grant.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   sif (slave)     requester handshakes, operands, response, drop pulse
//   alu_en          one-cycle ALU enable in ISSUE
//   alu_a/b/op      latched operands/opcode, held outside ISSUE
//   alu_c           registered ALU result, valid in CAPT
// Optional: define ALU_SCHED_TIMEOUT_EN to drop a response not accepted within
// RSP_TIMEOUT cycles of RESP entry; otherwise RESP waits forever and rsp_drop is 0.
module alu_rr_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned RSP_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    alu_rr_scheduler_if.slave  sif,
    output logic               alu_en,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [1:0]         alu_op,
    input  logic [4:0]         alu_c
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;

    state_e             state_q;
    logic [GW-1:0]      last_grant_q;
    logic [GW-1:0]      grant_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [4:0]         rsp_data_q;

    logic               found;
    logic [GW-1:0]      gnt_idx;
    logic [GW-1:0]      scan_idx;
    logic [3:0]         sel_a;
    logic [3:0]         sel_b;
    logic [1:0]         sel_op;

    // Rotating search starting just after the last granted requester.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = GW'((32'(last_grant_q) + i) % NUM_REQ);
            if (!found && sif.req_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == GW'(i)) begin
                sel_a  = sif.req_a[4*i +: 4];
                sel_b  = sif.req_b[4*i +: 4];
                sel_op = sif.req_op[2*i +: 2];
            end
        end
    end

    // Gated by rst so nothing is offered while reset is held.
    assign sif.req_ready = (rst && (state_q == StIdle) && found) ?
                           (NUM_REQ'(1) << gnt_idx) : '0;
    assign sif.rsp_valid = rsp_valid_q;
    assign sif.rsp_data  = rsp_data_q;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(RSP_TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          drop_q;
    assign sif.rsp_drop = drop_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^RSP_TIMEOUT;
    assign sif.rsp_drop   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            alu_en       <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            drop_q       <= 1'b0;
`endif
        end else begin
            alu_en <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
            drop_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_op  <= sel_op;
                        grant_q <= gnt_idx;
                        alu_en  <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: state_q <= StCapt;
                StCapt: begin
                    rsp_data_q  <= alu_c;
                    rsp_valid_q <= NUM_REQ'(1) << grant_q;
`ifdef ALU_SCHED_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                    state_q     <= StResp;
                end
                StResp: begin
                    if (sif.rsp_ready[grant_q]) begin
                        rsp_valid_q  <= '0;
                        last_grant_q <= grant_q;
                        state_q      <= StIdle;
                    end
`ifdef ALU_SCHED_TIMEOUT_EN
                    // Count would hit RSP_TIMEOUT at this edge: drop, so the pulse
                    // lands exactly RSP_TIMEOUT cycles after RESP entry.
                    else if (cnt_q == CW'(RSP_TIMEOUT - 1)) begin
                        rsp_valid_q  <= '0;
                        drop_q       <= 1'b1;
                        last_grant_q <= grant_q;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
